// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared widths and defaults for the clock divider bank
package clk_div_pkg;
  localparam int CH_MAX = 16;
  localparam int N_CH_DEF = 4;
  localparam int DIV_W_DEF = 32;
  localparam int DIV_RST_DEF = 8;
  function automatic int SEL_W(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clk_div_bank_if.sv
// clk_div_bank_if: enables, divisor write port and divided-clock outputs of the bank
interface clk_div_bank_if import clk_div_pkg::*; #(
  parameter int N_CH = N_CH_DEF,
  parameter int DIV_W = DIV_W_DEF
) ();
  localparam int SW = SEL_W(N_CH);
  logic [N_CH-1:0] en;
  logic div_we;
  logic [SW-1:0] div_sel;
  logic [DIV_W-1:0] div_data;
  logic [N_CH-1:0] clk_o;
  logic [N_CH-1:0] tick_o;
  logic [N_CH-1:0] div_pend;
  modport master (output en, div_we, div_sel, div_data, input clk_o, tick_o, div_pend);
  modport slave (input en, div_we, div_sel, div_data, output clk_o, tick_o, div_pend);
endinterface

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel; CLK_DIV_SHADOW_EN defers retunes to the next wrap
module clk_div_chan import clk_div_pkg::*; #(
  parameter int DIV_W = DIV_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic we_i,
  input  logic [DIV_W-1:0] data_i,
  output logic clk_o,
  output logic tick_o,
  output logic pend_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic clk_q, clk_d, tick_q, tick_d, wrap;
  assign wrap = en_i && cnt_q >= div_q;
`ifdef CLK_DIV_SHADOW_EN
  logic [DIV_W-1:0] shd_q, shd_d;
  logic pend_q, pend_d;
  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + DIV_W'(en_i);
    clk_d = clk_q ^ wrap;
    tick_d = wrap;
    div_d = wrap && pend_q ? shd_q : div_q;
    shd_d = we_i ? data_i : shd_q;
    pend_d = we_i || (pend_q && !wrap);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shd_q <= DIV_W'(DIV_RST);
      pend_q <= 1'b0;
    end else begin
      shd_q <= shd_d;
      pend_q <= pend_d;
    end
  end
  assign pend_o = pend_q;
`else
  always_comb begin
    cnt_d = we_i || wrap ? '0 : cnt_q + DIV_W'(en_i);
    clk_d = clk_q ^ (wrap && !we_i);
    tick_d = wrap && !we_i;
    div_d = we_i ? data_i : div_q;
  end
  assign pend_o = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      div_q <= DIV_W'(DIV_RST);
      clk_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      clk_q <= clk_d;
      tick_q <= tick_d;
    end
  end
  assign clk_o = clk_q;
  assign tick_o = tick_q;
endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: N_CH programmable clock dividers; CLK_DIV_SHADOW_EN selects glitch-free retune
module clk_div_bank import clk_div_pkg::*; #(
  parameter int N_CH = N_CH_DEF,
  parameter int DIV_W = DIV_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input logic clk,
  input logic rst,
  clk_div_bank_if.slave bus
);
  localparam int SW = SEL_W(N_CH);
  logic [N_CH-1:0] we, clk_v, tick_v, pend_v;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign we[i] = bus.div_we && bus.div_sel == SW'(i);
    clk_div_chan #(.DIV_W(DIV_W), .DIV_RST(DIV_RST)) u_chan (
      .clk(clk),
      .rst(rst),
      .en_i(bus.en[i]),
      .we_i(we[i]),
      .data_i(bus.div_data),
      .clk_o(clk_v[i]),
      .tick_o(tick_v[i]),
      .pend_o(pend_v[i])
    );
  end
  assign bus.clk_o = clk_v;
  assign bus.tick_o = tick_v;
  assign bus.div_pend = pend_v;
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed and random checks of the divider bank against a half-period model
module tb_clk_div_bank;
  import clk_div_pkg::*;
  localparam int N = 4;
  localparam int DW = 32;
  localparam int DR = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  clk_div_bank_if #(.N_CH(N), .DIV_W(DW)) bus ();
  clk_div_bank_if #(.N_CH(3), .DIV_W(DW)) bus3 ();
  clk_div_bank #(.N_CH(N), .DIV_W(DW), .DIV_RST(DR)) dut (.clk(clk), .rst(rst), .bus(bus));
  clk_div_bank #(.N_CH(3), .DIV_W(DW), .DIV_RST(DR)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
  int n_chk = 0;
  int n_fail = 0;
  longint unsigned m_div[N], m_age[N];
`ifdef CLK_DIV_SHADOW_EN
  longint unsigned m_shd[N];
`endif
  logic [N-1:0] m_clk, m_tick, m_pend;
  longint unsigned b_age;
  logic b_clk, b_tick;
  logic lvl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // m_age counts enabled cycles spent in the current half-period, which lasts div+1 cycles
  task automatic model();
    for (int c = 0; c < N; c++) begin
      logic fire, hit;
      fire = 1'b0;
      hit = bus.div_we && bus.div_sel == c;
      if (rst) begin
        m_div[c] = DR;
        m_age[c] = 0;
        m_clk[c] = 1'b0;
        m_pend[c] = 1'b0;
`ifdef CLK_DIV_SHADOW_EN
        m_shd[c] = DR;
`endif
      end else begin
`ifndef CLK_DIV_SHADOW_EN
        if (hit) begin
          m_div[c] = bus.div_data;
          m_age[c] = 0;
        end else
`endif
        if (bus.en[c]) begin
          m_age[c] = m_age[c] + 1;
          if (m_age[c] > m_div[c]) begin
            fire = 1'b1;
            m_age[c] = 0;
          end
        end
        m_clk[c] = m_clk[c] ^ fire;
`ifdef CLK_DIV_SHADOW_EN
        if (fire && m_pend[c]) begin
          m_div[c] = m_shd[c];
          m_pend[c] = 1'b0;
        end
        if (hit) begin
          m_shd[c] = bus.div_data;
          m_pend[c] = 1'b1;
        end
`endif
      end
      m_tick[c] = fire;
    end
    b_tick = 1'b0;
    if (rst) begin
      b_age = 0;
      b_clk = 1'b0;
    end else begin
      b_age = b_age + 1;
      if (b_age > DR) begin
        b_age = 0;
        b_tick = 1'b1;
        b_clk = ~b_clk;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk("clk_o", 32'(bus.clk_o), 32'(m_clk));
    chk("tick_o", 32'(bus.tick_o), 32'(m_tick));
    chk("div_pend", 32'(bus.div_pend), 32'(m_pend));
    chk("n3_clk_o", 32'(bus3.clk_o), 32'({3{b_clk}}));
    chk("n3_tick_o", 32'(bus3.tick_o), 32'({3{b_tick}}));
    chk("n3_div_pend", 32'(bus3.div_pend), 32'(0));
  endtask

  initial begin
    bus.en = '0;
    bus.div_we = 1'b0;
    bus.div_sel = '0;
    bus.div_data = '0;
    bus3.en = '1;
    bus3.div_we = 1'b0;
    bus3.div_sel = '0;
    bus3.div_data = '0;
    rst = 1'b1;
    step();
    step();
    chk("reset_clk", 32'(bus.clk_o), 32'(0));
    chk("reset_tick", 32'(bus.tick_o), 32'(0));
    rst = 1'b0;
    bus.en = '1;
    repeat (8) step();
    chk("ch0_low_c8", 32'(bus.clk_o[0]), 32'(0));
    step();
    chk("ch0_rise_c9", 32'(bus.clk_o[0]), 32'(1));
    chk("ch0_tick_c9", 32'(bus.tick_o[0]), 32'(1));
    repeat (8) step();
    chk("ch0_high_c17", 32'(bus.clk_o[0]), 32'(1));
    step();
    chk("ch0_fall_c18", 32'(bus.clk_o[0]), 32'(0));
    bus.div_we = 1'b1;
    bus.div_sel = 2'd1;
    bus.div_data = '0;
    step();
    bus.div_we = 1'b0;
    repeat (10) step();
    repeat (4) begin
      step();
      chk("ch1_tick_d0", 32'(bus.tick_o[1]), 32'(1));
    end
    for (int k = 0; k < 20 && m_age[2] != 4; k++) step();
    chk("ch2_reach_cnt4", 32'(m_age[2]), 32'(4));
    lvl = bus.clk_o[2];
    bus.div_we = 1'b1;
    bus.div_sel = 2'd2;
    bus.div_data = 32'd2;
    step();
    bus.div_we = 1'b0;
    chk("ch2_level_at_write", 32'(bus.clk_o[2]), 32'(lvl));
    repeat (24) step();
    for (int k = 0; k < 20 && m_age[3] != 6; k++) step();
    chk("ch3_reach_cnt6", 32'(m_age[3]), 32'(6));
    bus.en[3] = 1'b0;
    repeat (5) begin
      step();
      chk("ch3_tick_off", 32'(bus.tick_o[3]), 32'(0));
    end
    bus.en[3] = 1'b1;
    repeat (2) step();
    chk("ch3_no_early_tick", 32'(bus.tick_o[3]), 32'(0));
    step();
    chk("ch3_resume_tick", 32'(bus.tick_o[3]), 32'(1));
    bus3.div_we = 1'b1;
    bus3.div_sel = 2'd3;
    bus3.div_data = '0;
    step();
    bus3.div_we = 1'b0;
    repeat (10) step();
    bus.div_we = 1'b1;
    bus.div_sel = 2'd0;
    bus.div_data = 32'hFFFF_FFFF;
    step();
    bus.div_we = 1'b0;
    repeat (12) step();
    rst = 1'b1;
    bus.div_we = 1'b1;
    bus.div_sel = 2'd0;
    bus.div_data = 32'd3;
    step();
    rst = 1'b0;
    bus.div_we = 1'b0;
    chk("rst_we_clk", 32'(bus.clk_o), 32'(0));
    chk("rst_we_pend", 32'(bus.div_pend), 32'(0));
    repeat (8) step();
    chk("post_rst_low_c8", 32'(bus.clk_o[0]), 32'(0));
    step();
    chk("post_rst_rise_c9", 32'(bus.clk_o[0]), 32'(1));
    repeat (400) begin
      for (int c = 0; c < N; c++) bus.en[c] = $urandom_range(0, 7) != 0;
      bus.div_we = $urandom_range(0, 5) == 0;
      bus.div_sel = 2'($urandom_range(0, 3));
      bus.div_data = 32'($urandom_range(0, 12));
      bus3.div_we = $urandom_range(0, 7) == 0;
      bus3.div_sel = 2'd3;
      bus3.div_data = 32'($urandom_range(0, 3));
      rst = $urandom_range(0, 99) == 0;
      step();
    end
    rst = 1'b0;
    bus.div_we = 1'b0;
    bus3.div_we = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
